// File: rtl/fbf_mul_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : fbf_mul_scheduler_if
// Purpose  : Request/acknowledge bundle between the 4x4 matrix scheduler and
//            the shared 2x2 tile multiplier and tile adder.
// Revision : 1.0 - initial release
// ============================================================================
interface fbf_mul_scheduler_if #(
  parameter int FLOAT_SIZE = 32
);
  // Multiplier channel: tile operands out, tile product back.
  logic                    mul_req;
  logic [4*FLOAT_SIZE-1:0] mul_a;
  logic [4*FLOAT_SIZE-1:0] mul_b;
  logic                    mul_ack;
  logic [4*FLOAT_SIZE-1:0] mul_res;

  // Adder channel: two partial products out, tile sum back.
  logic                    add_req;
  logic [4*FLOAT_SIZE-1:0] add_a;
  logic [4*FLOAT_SIZE-1:0] add_b;
  logic                    add_ack;
  logic [4*FLOAT_SIZE-1:0] add_res;

  // Scheduler side.
  modport master (
    output mul_req, mul_a, mul_b,
    input  mul_ack, mul_res,
    output add_req, add_a, add_b,
    input  add_ack, add_res
  );

  // Datapath side.
  modport slave (
    input  mul_req, mul_a, mul_b,
    output mul_ack, mul_res,
    input  add_req, add_a, add_b,
    output add_ack, add_res
  );
endinterface
`default_nettype wire

// File: rtl/fbf_mul_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : fbf_mul_scheduler
// Purpose  : Computes C = A*B for 4x4 single-precision matrices by walking the
//            four 2x2 output tiles (00,01,10,11). Each tile takes two products
//            on the shared tile multiplier and one sum on the shared tile
//            adder, all over req/ack handshakes.
// Options  : FBF_SCHED_TIMEOUT_EN - abort with a sticky err when a request
//            waits TIMEOUT cycles without an acknowledge.
// Revision : 1.0 - initial release
// ============================================================================
module fbf_mul_scheduler #(
  parameter int FLOAT_SIZE = 32,
  parameter int TIMEOUT    = 255
) (
  input  wire logic                     clk,
  input  wire logic                     reset,
  input  wire logic                     start,
  input  wire logic [16*FLOAT_SIZE-1:0] A,
  input  wire logic [16*FLOAT_SIZE-1:0] B,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output logic [16*FLOAT_SIZE-1:0]      Res,
  fbf_mul_scheduler_if.master           dp
);

  localparam int FS     = FLOAT_SIZE;
  localparam int TILE_W = 4 * FS;
  localparam int MAT_W  = 16 * FS;

  // A zero or negative wait limit would abort every request immediately.
  if (TIMEOUT < 1) begin : g_timeout_range
    $error("fbf_mul_scheduler: TIMEOUT must be at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_ADD  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              state;
  logic [1:0]          tile_idx;   // output tile t: row block t[1], col block t[0]
  logic                kstep;      // which partial product is in flight
  logic [MAT_W-1:0]    a_q;
  logic [MAT_W-1:0]    b_q;
  logic [TILE_W-1:0]   p0;
  logic [TILE_W-1:0]   p1;
  logic [1:0]          tile_next;
  logic                timeout_hit;

  assign tile_next = tile_idx + 2'd1;

  // The adder always sums the two stored partial products.
  assign dp.add_a = p0;
  assign dp.add_b = p1;

  // Extract 2x2 tile (ti,tj) of a row-major 4x4 matrix.
  function automatic logic [TILE_W-1:0] get_tile(
    input logic [MAT_W-1:0] m,
    input logic             ti,
    input logic             tj
  );
    logic [TILE_W-1:0] tile;
    tile = '0;
    for (int lr = 0; lr < 2; lr++) begin
      for (int lc = 0; lc < 2; lc++) begin
        tile[FS*(2*lr+lc) +: FS] = m[FS*(4*(2*int'(ti)+lr) + 2*int'(tj) + lc) +: FS];
      end
    end
    return tile;
  endfunction

`ifdef FBF_SCHED_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  logic [WAIT_W-1:0] wait_cnt;
  logic              req_active;
  logic              ack_now;

  assign req_active = (state == S_MUL) || (state == S_ADD);
  assign ack_now    = ((state == S_MUL) && dp.mul_ack) || ((state == S_ADD) && dp.add_ack);

  // Count cycles the outstanding request has gone unanswered; restart per request.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (req_active && !ack_now) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end else begin
      wait_cnt <= '0;
    end
  end

  assign timeout_hit = req_active && (wait_cnt == WAIT_W'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // Main sequencer: accept, issue MUL/MUL/ADD per tile, assemble Res, pulse done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      tile_idx   <= 2'd0;
      kstep      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      Res        <= '0;
      a_q        <= '0;
      b_q        <= '0;
      p0         <= '0;
      p1         <= '0;
      dp.mul_req <= 1'b0;
      dp.mul_a   <= '0;
      dp.mul_b   <= '0;
      dp.add_req <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            // Operands for the first product come straight from the inputs
            // since the latch happens on this same edge.
            a_q        <= A;
            b_q        <= B;
            Res        <= '0;
            err        <= 1'b0;
            tile_idx   <= 2'd0;
            kstep      <= 1'b0;
            busy       <= 1'b1;
            dp.mul_req <= 1'b1;
            dp.mul_a   <= get_tile(A, 1'b0, 1'b0);
            dp.mul_b   <= get_tile(B, 1'b0, 1'b0);
            state      <= S_MUL;
          end
        end

        S_MUL: begin
          if (dp.mul_ack) begin
            if (!kstep) begin
              // First product in; keep req high and present A_i1 * B_1j.
              p0       <= dp.mul_res;
              kstep    <= 1'b1;
              dp.mul_a <= get_tile(a_q, tile_idx[1], 1'b1);
              dp.mul_b <= get_tile(b_q, 1'b1, tile_idx[0]);
            end else begin
              p1         <= dp.mul_res;
              dp.mul_req <= 1'b0;
              dp.add_req <= 1'b1;
              state      <= S_ADD;
            end
          end else if (timeout_hit) begin
            dp.mul_req <= 1'b0;
            err        <= 1'b1;
            done       <= 1'b1;
            state      <= S_DONE;
          end
        end

        S_ADD: begin
          if (dp.add_ack) begin
            for (int lr = 0; lr < 2; lr++) begin
              for (int lc = 0; lc < 2; lc++) begin
                Res[FS*(4*(2*int'(tile_idx[1])+lr) + 2*int'(tile_idx[0]) + lc) +: FS]
                  <= dp.add_res[FS*(2*lr+lc) +: FS];
              end
            end
            dp.add_req <= 1'b0;
            if (tile_idx == 2'd3) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              // Next tile's first product follows the sum back-to-back.
              tile_idx   <= tile_next;
              kstep      <= 1'b0;
              dp.mul_req <= 1'b1;
              dp.mul_a   <= get_tile(a_q, tile_next[1], 1'b0);
              dp.mul_b   <= get_tile(b_q, 1'b0, tile_next[0]);
              state      <= S_MUL;
            end
          end else if (timeout_hit) begin
            dp.add_req <= 1'b0;
            err        <= 1'b1;
            done       <= 1'b1;
            state      <= S_DONE;
          end
        end

        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fbf_mul_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_fbf_mul_scheduler
// Purpose  : Self-checking bench for fbf_mul_scheduler. The external tile
//            units are modelled with wrapping 32-bit integer arithmetic, so a
//            misrouted element or tile shows up as a wrong value; results are
//            compared with a plain 4x4 triple-loop matrix product.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fbf_mul_scheduler;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [511:0] a_in;
  logic [511:0] b_in;
  logic         busy;
  logic         done;
  logic         err;
  logic [511:0] res;

  fbf_mul_scheduler_if #(.FLOAT_SIZE(32)) dp_if ();

  fbf_mul_scheduler #(
    .FLOAT_SIZE(32),
    .TIMEOUT   (8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .A    (a_in),
    .B    (b_in),
    .busy (busy),
    .done (done),
    .err  (err),
    .Res  (res),
    .dp   (dp_if)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Datapath behaviour knobs and bookkeeping shared with the main sequence.
  int           max_delay  = 0;
  bit           stall      = 1'b0;
  bit           spurious   = 1'b0;
  int           wait_total = 0;
  logic [256:0] req_log[$];

  logic [511:0] mat_a;
  logic [511:0] mat_b;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] tile(input logic [511:0] m, input int ti, input int tj);
    logic [127:0] x;
    x = '0;
    for (int lr = 0; lr < 2; lr++)
      for (int lc = 0; lc < 2; lc++)
        x[32*(2*lr+lc) +: 32] = m[32*(4*(2*ti+lr) + 2*tj + lc) +: 32];
    return x;
  endfunction

  function automatic logic [127:0] mm2(input logic [127:0] p, input logic [127:0] q);
    logic [127:0] x;
    logic [31:0]  s;
    x = '0;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) begin
        s = p[32*(2*r) +: 32] * q[32*c +: 32] + p[32*(2*r+1) +: 32] * q[32*(2+c) +: 32];
        x[32*(2*r+c) +: 32] = s;
      end
    return x;
  endfunction

  function automatic logic [127:0] add2(input logic [127:0] p, input logic [127:0] q);
    logic [127:0] x;
    for (int e = 0; e < 4; e++) x[32*e +: 32] = p[32*e +: 32] + q[32*e +: 32];
    return x;
  endfunction

  function automatic logic [511:0] ref_matmul(input logic [511:0] a, input logic [511:0] b);
    logic [511:0] c;
    logic [31:0]  acc;
    for (int r = 0; r < 4; r++)
      for (int col = 0; col < 4; col++) begin
        acc = '0;
        for (int k = 0; k < 4; k++) acc = acc + a[32*(4*r+k) +: 32] * b[32*(4*k+col) +: 32];
        c[32*(4*r+col) +: 32] = acc;
      end
    return c;
  endfunction

  // Expected n-th handshake: {is_mul, operand_a, operand_b}.
  function automatic logic [256:0] exp_txn(input logic [511:0] a, input logic [511:0] b, input int n);
    int t, s, i, j;
    t = n / 3; s = n % 3; i = t / 2; j = t % 2;
    if (s < 2) return {1'b1, tile(a, i, s), tile(b, s, j)};
    return {1'b0, mm2(tile(a, i, 0), tile(b, 0, j)), mm2(tile(a, i, 1), tile(b, 1, j))};
  endfunction

  function automatic logic [511:0] rand_mat();
    logic [511:0] m;
    for (int e = 0; e < 16; e++) m[32*e +: 32] = $urandom;
    return m;
  endfunction

  // External tile multiplier/adder: acks after a random wait, results on ack.
  initial begin : responder
    logic [127:0] cap_a, cap_b;
    int           wait_left;
    bit           in_txn, is_mul;
    dp_if.mul_ack = 1'b0; dp_if.mul_res = '0;
    dp_if.add_ack = 1'b0; dp_if.add_res = '0;
    in_txn = 1'b0; wait_left = 0; is_mul = 1'b0; cap_a = '0; cap_b = '0;
    forever begin
      @(negedge clk);
      dp_if.mul_ack = 1'b0;
      dp_if.add_ack = 1'b0;
      if (!(dp_if.mul_req || dp_if.add_req)) begin
        in_txn = 1'b0;
      end else begin
        if (!in_txn) begin
          in_txn = 1'b1;
          is_mul = dp_if.mul_req;
          cap_a  = is_mul ? dp_if.mul_a : dp_if.add_a;
          cap_b  = is_mul ? dp_if.mul_b : dp_if.add_b;
          if (stall) wait_left = 1 << 30;
          else begin
            wait_left  = (max_delay == 0) ? 0 : int'($urandom_range(max_delay, 0));
            wait_total = wait_total + wait_left;
          end
          req_log.push_back({is_mul, cap_a, cap_b});
        end else begin
          check("operand_hold",
                is_mul ? {dp_if.mul_a, dp_if.mul_b} : {dp_if.add_a, dp_if.add_b},
                {cap_a, cap_b});
        end
        if (wait_left == 0) begin
          in_txn = 1'b0;
          if (is_mul) begin dp_if.mul_ack = 1'b1; dp_if.mul_res = mm2(cap_a, cap_b); end
          else        begin dp_if.add_ack = 1'b1; dp_if.add_res = add2(cap_a, cap_b); end
        end else begin
          wait_left--;
          if (spurious && is_mul) begin
            dp_if.add_ack = 1'b1;
            dp_if.add_res = {$urandom, $urandom, $urandom, $urandom};
          end
        end
      end
    end
  end

  // One full operation on mat_a/mat_b with latency, result and sequence checks.
  task automatic run_op(input string tag, input bit poke_start);
    int           lat;
    logic [511:0] exp_res;
    exp_res = ref_matmul(mat_a, mat_b);
    @(negedge clk);
    start = 1'b1; a_in = mat_a; b_in = mat_b;
    wait_total = 0; req_log.delete();
    @(negedge clk);
    start = 1'b0;
    a_in  = ~mat_a; b_in = rand_mat();   // post-accept input changes must not matter
    check({tag, "/busy_rise"}, busy, 1'b1);
    check({tag, "/mulreq_rise"}, dp_if.mul_req, 1'b1);
    check({tag, "/res_cleared"}, res, '0);
    check({tag, "/err_clear"}, err, 1'b0);
    lat = 1;
    while (done !== 1'b1 && lat < 600) begin
      start = poke_start && (lat == 4);
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check({tag, "/latency"}, lat, 13 + wait_total);
    check({tag, "/result"}, res, exp_res);
    check({tag, "/req_count"}, req_log.size(), 12);
    for (int n = 0; n < req_log.size() && n < 12; n++)
      check({tag, "/req_seq"}, req_log[n], exp_txn(mat_a, mat_b, n));
    @(negedge clk);
    check({tag, "/done_pulse"}, {busy, done}, 2'b00);
    check({tag, "/res_hold"}, res, exp_res);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog observed=no_finish expected=finish");
    $fatal(1, "simulation time limit");
  end

  initial begin : main_seq
    int           cyc;
    bit           seen_done;
    logic [511:0] all16;
    reset = 1'b1; start = 1'b0; a_in = '0; b_in = '0;
    repeat (3) @(negedge clk);
    check("rst/busy", busy, 1'b0);
    check("rst/done", done, 1'b0);
    check("rst/err", err, 1'b0);
    check("rst/mul_req", dp_if.mul_req, 1'b0);
    check("rst/add_req", dp_if.add_req, 1'b0);
    check("rst/res", res, '0);
    reset = 1'b0;

    // Identity times 1..16, zero-wait units.
    mat_a = '0;
    for (int d = 0; d < 4; d++) mat_a[32*(5*d) +: 32] = 32'd1;
    for (int e = 0; e < 16; e++) mat_b[32*e +: 32] = 32'(e + 1);
    max_delay = 0;
    run_op("ident", 1'b0);
    check("ident/equals_b", res, mat_b);

    // All twos: every element of C is 4*2*2 = 16.
    for (int e = 0; e < 16; e++) begin
      mat_a[32*e +: 32] = 32'd2;
      mat_b[32*e +: 32] = 32'd2;
      all16[32*e +: 32] = 32'd16;
    end
    run_op("twos", 1'b0);
    check("twos/all16", res, all16);

    // Random data with random acknowledge delays.
    max_delay = 5;
    repeat (3) begin
      mat_a = rand_mat(); mat_b = rand_mat();
      run_op("rand", 1'b0);
    end

    // start pulsed while busy plus stray add_ack during MUL waits.
    spurious = 1'b1;
    mat_a = rand_mat(); mat_b = rand_mat();
    run_op("ignore", 1'b1);
    spurious = 1'b0;

    // Reset during the ADD of tile 2, then a clean operation.
    max_delay = 3;
    mat_a = rand_mat(); mat_b = rand_mat();
    @(negedge clk);
    start = 1'b1; a_in = mat_a; b_in = mat_b; req_log.delete();
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!(dp_if.add_req === 1'b1 && req_log.size() >= 8) && cyc < 300) begin
      @(negedge clk); cyc++;
    end
    check("midrst/reached_tile2_add", cyc < 300, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    check("midrst/outputs", {busy, done, err, dp_if.mul_req, dp_if.add_req}, 5'b0);
    check("midrst/res", res, '0);
    reset = 1'b0;
    @(negedge clk);
    check("midrst/idle", {busy, dp_if.mul_req}, 2'b00);
    mat_a = rand_mat(); mat_b = rand_mat();
    run_op("after_rst", 1'b0);

    // Multiplier never acknowledges.
    stall = 1'b1;
    mat_a = rand_mat(); mat_b = rand_mat();
    @(negedge clk);
    start = 1'b1; a_in = mat_a; b_in = mat_b;
    @(negedge clk);
    start = 1'b0;
    check("stall/mulreq_rise", dp_if.mul_req, 1'b1);
`ifdef FBF_SCHED_TIMEOUT_EN
    cyc = 1;
    while (done !== 1'b1 && cyc < 100) begin @(negedge clk); cyc++; end
    check("timeout/done_cycle", cyc, 9);
    check("timeout/err", err, 1'b1);
    @(negedge clk);
    check("timeout/err_sticky", {err, busy, done}, 3'b100);
    stall = 1'b0;
    mat_a = rand_mat(); mat_b = rand_mat();
    run_op("post_timeout", 1'b0);
`else
    seen_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) seen_done = 1'b1;
    end
    check("stall/busy_held", busy, 1'b1);
    check("stall/no_done", seen_done, 1'b0);
    check("stall/no_err", err, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    stall = 1'b0;
    mat_a = rand_mat(); mat_b = rand_mat();
    run_op("post_stall", 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
